fpu_cpu_bridge: RTL and testbench

Initiator side of the FPU command interface. It turns byte-wide CPU register accesses into FPU operations. The block assembles the 32-bit A and B operands from byte writes, drives the start/cmd_end handshake to the fpu block, captures the IEEE-754 result, and exposes status, result bytes and an interrupt on the 8-bit CPU bus.

---
 rtl/fpu_cpu_bridge.sv | 174 +++++++++++++++++
 tb/tb_fpu_cpu_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cpu_bridge.sv
// CPU-to-FPU command bridge: byte-wide register file, start/cmd_end handshake, result capture and irq.
// Optional watchdog on the ISSUE state is built when FPU_BRIDGE_TIMEOUT_EN is defined.

package pa_fpu;
    typedef enum logic [3:0] {
        FPU_ADD   = 4'd0,
        FPU_SUB   = 4'd1,
        FPU_MUL   = 4'd2,
        FPU_DIV   = 4'd3,
        FPU_SQRT  = 4'd4,
        FPU_MIN   = 4'd5,
        FPU_MAX   = 4'd6,
        FPU_CMP   = 4'd7,
        FPU_I2F   = 4'd8,
        FPU_F2I   = 4'd9,
        FPU_ABS   = 4'd10,
        FPU_NEG   = 4'd11,
        FPU_RSV12 = 4'd12,
        FPU_RSV13 = 4'd13,
        FPU_RSV14 = 4'd14,
        FPU_RSV15 = 4'd15
    } e_fpu_op;
endpackage

module fpu_cpu_bridge #(
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            cs,
    input  logic            wr,
    input  logic            rd,
    input  logic [3:0]      addr,
    input  logic [7:0]      data_in,
    output logic [7:0]      data_out,
    output logic            irq,
    output logic            fpu_start,
    output logic [31:0]     fpu_a_operand,
    output logic [31:0]     fpu_b_operand,
    output pa_fpu::e_fpu_op fpu_operation,
    input  logic            fpu_cmd_end,
    input  logic            fpu_busy,
    input  logic [31:0]     fpu_result
);

    localparam int ENUM_W = $bits(pa_fpu::e_fpu_op);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state;
    logic [OP_W-1:0] op_reg;
    logic            irq_en;
    logic [31:0]     result_reg;
    logic            done;
    logic            overrun;
    logic            timeout;
    logic            wr_en;
    logic            rd_en;
    logic            status_rd;
    logic            reg_wr;
    logic            cmd_wr;
    logic            issue_expired;
    logic [7:0]      status;

    assign wr_en     = cs & wr;
    assign rd_en     = cs & rd;
    assign status_rd = rd_en & (addr == 4'h9);
    assign reg_wr    = wr_en & (addr <= 4'h8);
    assign cmd_wr    = wr_en & (addr == 4'h8);

`ifdef FPU_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] issue_cnt;

    // Counts completed ISSUE cycles; held at zero outside ISSUE so each launch starts fresh.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            issue_cnt <= '0;
        end else if (state != ISSUE) begin
            issue_cnt <= '0;
        end else if (!fpu_cmd_end && !issue_expired) begin
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

    assign issue_expired = (issue_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign issue_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= IDLE;
            fpu_start     <= 1'b0;
            fpu_a_operand <= '0;
            fpu_b_operand <= '0;
            op_reg        <= '0;
            irq_en        <= 1'b0;
            result_reg    <= '0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            // Sticky bits clear on a status read; any set later in this block wins.
            if (status_rd) begin
                done    <= 1'b0;
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (reg_wr && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wr_en && addr[3:2] == 2'b00) begin
                        fpu_a_operand[{addr[1:0], 3'b000} +: 8] <= data_in;
                    end
                    if (wr_en && addr[3:2] == 2'b01) begin
                        fpu_b_operand[{addr[1:0], 3'b000} +: 8] <= data_in;
                    end
                    if (cmd_wr) begin
                        op_reg    <= data_in[OP_W-1:0];
                        irq_en    <= data_in[7];
                        done      <= 1'b0;
                        fpu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fpu_cmd_end) begin
                        result_reg <= fpu_result;
                        fpu_start  <= 1'b0;
                        done       <= 1'b1;
                        state      <= DRAIN;
                    end else if (issue_expired) begin
                        fpu_start <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A cmd_end still high from the last command must not be mistaken for a new one.
                    if (!fpu_cmd_end && !fpu_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    fpu_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign status        = {4'b0000, timeout, overrun, done, (state != IDLE)};
    assign irq           = done & irq_en;
    assign fpu_operation = pa_fpu::e_fpu_op'(ENUM_W'(op_reg));

    always_comb begin
        data_out = 8'h00;
        if (rd_en) begin
            case (addr)
                4'h0, 4'h1, 4'h2, 4'h3: data_out = fpu_a_operand[{addr[1:0], 3'b000} +: 8];
                4'h4, 4'h5, 4'h6, 4'h7: data_out = fpu_b_operand[{addr[1:0], 3'b000} +: 8];
                4'h9:                   data_out = status;
                4'hC, 4'hD, 4'hE, 4'hF: data_out = result_reg[{addr[1:0], 3'b000} +: 8];
                default:                data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cpu_bridge.sv
// Self-checking bench for fpu_cpu_bridge: FPU responder model, transaction-level reference model,
// directed scenarios with literal expectations and a randomized bus phase.

module tb_fpu_cpu_bridge;

    localparam int TO = 16;
`ifdef FPU_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk     = 1'b0;
    logic            arst    = 1'b1;
    logic            cs      = 1'b0;
    logic            wr      = 1'b0;
    logic            rd      = 1'b0;
    logic [3:0]      addr    = 4'h0;
    logic [7:0]      data_in = 8'h00;
    logic [7:0]      data_out;
    logic            irq;
    logic            fpu_start;
    logic [31:0]     fpu_a_operand;
    logic [31:0]     fpu_b_operand;
    pa_fpu::e_fpu_op fpu_operation;
    logic            fpu_cmd_end;
    logic            fpu_busy;
    logic [31:0]     fpu_result;

    int pass_cnt  = 0;
    int check_cnt = 0;
    bit cmp_en    = 1'b0;

    always #5 clk = ~clk;

    fpu_cpu_bridge #(.OP_W(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .arst         (arst),
        .cs           (cs),
        .wr           (wr),
        .rd           (rd),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .irq          (irq),
        .fpu_start    (fpu_start),
        .fpu_a_operand(fpu_a_operand),
        .fpu_b_operand(fpu_b_operand),
        .fpu_operation(fpu_operation),
        .fpu_cmd_end  (fpu_cmd_end),
        .fpu_busy     (fpu_busy),
        .fpu_result   (fpu_result)
    );

    // FPU responder: after seeing start it works fm_lat cycles, then holds cmd_end for fm_hold cycles.
    int          fm_lat   = 10;
    int          fm_hold  = 1;
    logic [31:0] fm_val   = 32'h0;
    bit          fm_rand  = 1'b0;
    bit          fm_never = 1'b0;
    int          fm_phase = 0;
    int          fm_cnt   = 0;
    int          fm_left  = 0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            fpu_cmd_end <= 1'b0;
            fpu_busy    <= 1'b0;
            fpu_result  <= 32'h0;
            fm_phase = 0;
        end else begin
            if (fm_rand && fm_phase != 2) fpu_result <= $urandom;
            case (fm_phase)
                0: if (fpu_start) begin
                    if (fm_rand) begin
                        fm_lat  = $urandom_range(1, 6);
                        fm_hold = $urandom_range(1, 4);
                        fm_val  = $urandom;
                    end
                    fpu_busy <= 1'b1;
                    fm_cnt = 1;
                    if (!fm_never && fm_lat <= 1) begin
                        fpu_cmd_end <= 1'b1;
                        fpu_result  <= fm_val;
                        fm_left  = fm_hold;
                        fm_phase = 2;
                    end else begin
                        fm_phase = 1;
                    end
                end
                1: if (!fpu_start) begin
                    fpu_busy <= 1'b0;
                    fm_phase = 0;
                end else begin
                    fm_cnt++;
                    if (!fm_never && fm_cnt >= fm_lat) begin
                        fpu_cmd_end <= 1'b1;
                        fpu_result  <= fm_val;
                        fm_left  = fm_hold;
                        fm_phase = 2;
                    end
                end
                default: begin
                    fm_left--;
                    if (fm_left <= 0) begin
                        fpu_cmd_end <= 1'b0;
                        fpu_busy    <= 1'b0;
                        fm_phase = 0;
                    end
                end
            endcase
        end
    end

    // Reference model: register file as byte arrays, phase 0 = idle, 1 = waiting for end, 2 = draining.
    logic [7:0] m_a [4];
    logic [7:0] m_b [4];
    logic [7:0] m_res [4];
    logic [3:0] m_op;
    bit         m_irq_en, m_done, m_ovr, m_to;
    int         m_phase, m_cnt, m_addr;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < 4; k++) begin
                m_a[k] = 8'h00; m_b[k] = 8'h00; m_res[k] = 8'h00;
            end
            m_op = 4'h0; m_irq_en = 0; m_done = 0; m_ovr = 0; m_to = 0;
            m_phase = 0; m_cnt = 0;
        end else begin
            m_addr = int'(addr);
            if (cs && rd && m_addr == 9) begin
                m_done = 0; m_ovr = 0; m_to = 0;
            end
            if (cs && wr && m_addr <= 8 && m_phase != 0) m_ovr = 1;
            if (m_phase == 0) begin
                if (cs && wr) begin
                    if (m_addr < 4) m_a[m_addr] = data_in;
                    else if (m_addr < 8) m_b[m_addr - 4] = data_in;
                    else if (m_addr == 8) begin
                        m_op = data_in[3:0]; m_irq_en = data_in[7]; m_done = 0;
                        m_phase = 1; m_cnt = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (fpu_cmd_end) begin
                    for (int k = 0; k < 4; k++) m_res[k] = fpu_result[8*k +: 8];
                    m_done = 1; m_phase = 2;
                end else begin
                    m_cnt++;
                    if (TO_EN && m_cnt == TO) begin
                        m_done = 1; m_to = 1; m_phase = 2;
                    end
                end
            end else if (!fpu_cmd_end && !fpu_busy) begin
                m_phase = 0;
            end
        end
    end

    function automatic logic [7:0] expRead(input logic [3:0] a);
        int ia = int'(a);
        if (!(cs && rd)) return 8'h00;
        if (ia < 4) return m_a[ia];
        if (ia < 8) return m_b[ia - 4];
        if (ia == 9) return {4'h0, m_to, m_ovr, m_done, m_phase != 0};
        if (ia >= 12) return m_res[ia - 12];
        return 8'h00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_data_out", 32'(data_out), 32'(expRead(addr)));
            checkOutput("model_irq", 32'(irq), 32'(m_done & m_irq_en));
            checkOutput("model_fpu_start", 32'(fpu_start), 32'(m_phase == 1));
            checkOutput("model_a_operand", fpu_a_operand, {m_a[3], m_a[2], m_a[1], m_a[0]});
            checkOutput("model_b_operand", fpu_b_operand, {m_b[3], m_b[2], m_b[1], m_b[0]});
            checkOutput("model_operation", 32'(fpu_operation), 32'(m_op));
        end
    end

    task automatic applyStimulus(input bit w, input bit r, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cs = w | r; wr = w; rd = r; addr = a; data_in = d;
        @(negedge clk);
    endtask

    task automatic readCheck(input logic [3:0] a, input logic [7:0] exp, input string name);
        applyStimulus(1'b0, 1'b1, a, 8'h00);
        checkOutput(name, 32'(data_out), 32'(exp));
    endtask

    task automatic writeWord(input logic [3:0] base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, base + 4'(k), w[8*k +: 8]);
    endtask

    task automatic waitStartFall(output int high_cycles, output bit seen);
        bit was_high = 1'b0;
        high_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
            if (fpu_start) begin
                high_cycles++;
                was_high = 1'b1;
            end else if (was_high) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  hc;
        bit  seen;
        int  rises;
        bit  prev;
        int  r;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        cmp_en = 1'b1;

        $display("[TB] reset state");
        readCheck(4'h9, 8'h00, "reset_status");
        checkOutput("reset_start", 32'(fpu_start), 32'h0);

        $display("[TB] operands and launch");
        fm_lat = 10; fm_hold = 1; fm_val = 32'h42400000;
        writeWord(4'h0, 32'h41800000);
        writeWord(4'h4, 32'h42000000);
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h80);
        waitStartFall(hc, seen);
        checkOutput("launch_start_fall", 32'(seen), 32'h1);
        checkOutput("launch_start_cycles", 32'(hc), 32'd11);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("launch_irq_set", 32'(irq), 32'h1);
        checkOutput("launch_a", fpu_a_operand, 32'h41800000);
        readCheck(4'hC, 8'h00, "result_byte0");
        readCheck(4'hD, 8'h00, "result_byte1");
        readCheck(4'hE, 8'h40, "result_byte2");
        readCheck(4'hF, 8'h42, "result_byte3");
        readCheck(4'h9, 8'h02, "launch_status");
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("irq_after_read", 32'(irq), 32'h0);

        $display("[TB] overrun and stale cmd_end");
        fm_lat = 10; fm_hold = 5; fm_val = 32'h3F800000;
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h00);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h01);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("overrun_a_kept", fpu_a_operand, 32'h41800000);
        checkOutput("overrun_op_kept", 32'(fpu_operation), 32'h0);
        waitStartFall(hc, seen);
        checkOutput("overrun_start_fall", 32'(seen), 32'h1);
        readCheck(4'h9, 8'h07, "overrun_status");
        readCheck(4'h9, 8'h01, "overrun_status_busy_kept");
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h80);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
            checkOutput("drain_no_relaunch", 32'(fpu_start), 32'h0);
        end
        readCheck(4'h9, 8'h04, "drain_write_overrun");
        fm_lat = 3; fm_hold = 1;
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h81);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
            if (fpu_start && !prev) rises++;
            prev = fpu_start;
        end
        checkOutput("single_launch", 32'(rises), 32'd1);
        checkOutput("relaunch_op", 32'(fpu_operation), 32'h1);
        checkOutput("relaunch_irq", 32'(irq), 32'h1);
        readCheck(4'h9, 8'h02, "relaunch_status");

`ifdef FPU_BRIDGE_TIMEOUT_EN
        $display("[TB] timeout");
        fm_never = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h00);
        waitStartFall(hc, seen);
        checkOutput("timeout_start_fall", 32'(seen), 32'h1);
        checkOutput("timeout_start_cycles", 32'(hc), 32'd16);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        readCheck(4'h9, 8'h0A, "timeout_status");
        readCheck(4'hE, 8'h80, "timeout_result_kept2");
        readCheck(4'hF, 8'h3F, "timeout_result_kept3");
        fm_never = 1'b0;
`endif

        $display("[TB] reset mid-operation");
        fm_lat = 10; fm_hold = 1;
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h80);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("pre_reset_start", 32'(fpu_start), 32'h1);
        cs = 1'b1; rd = 1'b1; addr = 4'h3;
        #1;
        arst = 1'b1;
        #1;
        checkOutput("async_reset_start", 32'(fpu_start), 32'h0);
        checkOutput("async_reset_irq", 32'(irq), 32'h0);
        checkOutput("async_reset_data_out", 32'(data_out), 32'h0);
        checkOutput("async_reset_a", fpu_a_operand, 32'h0);
        checkOutput("async_reset_b", fpu_b_operand, 32'h0);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        readCheck(4'h9, 8'h00, "post_reset_status");

        $display("[TB] read-back and decode");
        writeWord(4'h4, 32'h3E800000);
        readCheck(4'h4, 8'h00, "b_byte0");
        readCheck(4'h5, 8'h00, "b_byte1");
        readCheck(4'h6, 8'h80, "b_byte2");
        readCheck(4'h7, 8'h3E, "b_byte3");
        readCheck(4'hA, 8'h00, "unmapped_read");
        checkOutput("b_operand_word", fpu_b_operand, 32'h3E800000);

        $display("[TB] randomized traffic");
        fm_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
            else if (r < 70) applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
            else applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'h00);
        end
        repeat (20) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
